// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC and IR, computes the next PC, decodes the IR into fields,
// and freezes fetch on a halt opcode or an illegal next PC until reset.
module instruction_fetch_unit #(
    parameter int unsigned MEM_BYTES = 128,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP   = 6'b111111
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic        IRWre,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] RegRs,
    input  logic [31:0] IDataIn,
    output logic [31:0] IAddr,
    output logic        RW,
    output logic [31:0] IR,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] Immediate,
    output logic [4:0]  Sa,
    output logic [31:0] PC4,
    output logic [31:0] JumpPC,
    output logic        Halted,
    output logic        Fault
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;

    logic [31:0] pc4;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;
    logic [31:0] next_pc;
    logic [31:0] next_pc_last;
    logic        next_legal;

    // Next-PC candidates always come from the pre-edge PC and IR.
    always_comb begin
        pc4          = pc_q + 32'd4;
        branch_pc    = pc4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
        jump_pc      = {pc4[31:28], ir_q[25:0], 2'b00};
        next_pc      = pc4;
        case (PCSrc)
            2'b00:   next_pc = pc4;
            2'b01:   next_pc = branch_pc;
            2'b10:   next_pc = RegRs;
            2'b11:   next_pc = jump_pc;
            default: next_pc = pc4;
        endcase
        // Last byte of the word must be in memory; a wrapped sum is huge and fails here.
        next_pc_last = next_pc + 32'd3;
        next_legal   = (next_pc[1:0] == 2'b00) && (next_pc_last < MEM_LIMIT);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            RUN: begin
                if (IRWre) begin
                    ir_d = IDataIn;
                    if (IDataIn[31:26] == HALT_OP) begin
                        state_d = HALT;
                    end
                end
                // Evaluated after the halt check so a fault on the same edge wins.
                if (PCWre) begin
                    if (next_legal) begin
                        pc_d = next_pc;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign IAddr     = pc_q;
    assign RW        = (state_q == RUN);
    assign Halted    = (state_q == HALT);
    assign Fault     = (state_q == FAULT);
    assign IR        = ir_q;
    assign op        = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign Immediate = ir_q[15:0];
    assign Sa        = ir_q[10:6];
    assign PC4       = pc4;
    assign JumpPC    = jump_pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a randomized
// run compared against a behavioural model of the fetch rules.
module tb_instruction_fetch_unit;

    localparam int unsigned MEM_BYTES = 128;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        PCWre = 1'b0;
    logic        IRWre = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic [31:0] RegRs = 32'd0;
    logic [31:0] IDataIn = 32'd0;
    logic [31:0] IAddr;
    logic        RW;
    logic [31:0] IR;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, Sa;
    logic [15:0] Immediate;
    logic [31:0] PC4, JumpPC;
    logic        Halted, Fault;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    bit          m_halted;
    bit          m_fault;

    logic [7:0]  mem [MEM_BYTES];

    instruction_fetch_unit #(
        .MEM_BYTES(MEM_BYTES),
        .RESET_PC (32'h0000_0000),
        .HALT_OP  (6'b111111)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .PCWre    (PCWre),
        .IRWre    (IRWre),
        .PCSrc    (PCSrc),
        .RegRs    (RegRs),
        .IDataIn  (IDataIn),
        .IAddr    (IAddr),
        .RW       (RW),
        .IR       (IR),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .Immediate(Immediate),
        .Sa       (Sa),
        .PC4      (PC4),
        .JumpPC   (JumpPC),
        .Halted   (Halted),
        .Fault    (Fault)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a + 32'd3 < MEM_BYTES)
            return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
        return 32'd0;
    endfunction

    // Apply one clock of the fetch rules to the model.
    task automatic model_step(input bit pcwre, input bit irwre, input logic [1:0] src,
                              input logic [31:0] regrs, input logic [31:0] idata);
        logic [31:0] target, last;
        int          off;
        bit          go_halt, go_fault;
        if (m_halted || m_fault) return;
        off = $signed(m_ir[15:0]) * 4;
        case (src)
            2'd0:    target = m_pc + 4;
            2'd1:    target = m_pc + 4 + 32'(off);
            2'd2:    target = regrs;
            default: target = ((m_pc + 4) & 32'hF000_0000) | (32'(m_ir[25:0]) * 4);
        endcase
        last     = target + 3;
        go_fault = pcwre && ((target % 4) != 0 || last >= MEM_BYTES);
        go_halt  = irwre && (idata[31:26] == 6'h3F);
        if (pcwre && !go_fault) m_pc = target;
        if (irwre) m_ir = idata;
        if (go_fault) m_fault = 1;
        else if (go_halt) m_halted = 1;
    endtask

    task automatic tick(input bit pcwre, input bit irwre, input logic [1:0] src,
                        input logic [31:0] regrs, input logic [31:0] idata);
        @(negedge CLK);
        PCWre = pcwre; IRWre = irwre; PCSrc = src; RegRs = regrs; IDataIn = idata;
        model_step(pcwre, irwre, src, regrs, idata);
        @(posedge CLK);
        #1;
        PCWre = 1'b0; IRWre = 1'b0;
    endtask

    // Pulse reset between edges and check the state is forced without a clock edge.
    task automatic test_reset();
        @(negedge CLK);
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (IAddr !== 32'd0 || IR !== 32'd0 || PC4 !== 32'd4 || RW !== 1'b1 ||
            Halted !== 1'b0 || Fault !== 1'b0) begin
            errors++;
            $display("FAIL reset: got pc=%h ir=%h pc4=%h rw=%b h=%b f=%b want pc=0 ir=0 pc4=4 rw=1 h=0 f=0",
                     IAddr, IR, PC4, RW, Halted, Fault);
        end
        #1 Reset = 1'b0;
        m_pc = 32'd0; m_ir = 32'd0; m_halted = 0; m_fault = 0;
        $display("reset pulse: pc=%h ir=%h rw=%b", IAddr, IR, RW);
    endtask

    task automatic test_sequential();
        test_reset();
        tick(1, 1, 2'b00, 32'd0, 32'h2001_0005);
        checks++;
        if (IAddr !== 32'd4 || IR !== 32'h2001_0005 || rt !== 5'd1 || Immediate !== 16'd5) begin
            errors++;
            $display("FAIL seq_fetch0: got pc=%h ir=%h rt=%0d imm=%h want pc=4 ir=20010005 rt=1 imm=0005",
                     IAddr, IR, rt, Immediate);
        end
        $display("seq fetch 0: pc=%h ir=%h", IAddr, IR);
        tick(1, 1, 2'b00, 32'd0, 32'h2002_0007);
        checks++;
        if (IAddr !== 32'd8 || IR !== 32'h2002_0007 || rt !== 5'd2 || Immediate !== 16'd7) begin
            errors++;
            $display("FAIL seq_fetch1: got pc=%h ir=%h rt=%0d imm=%h want pc=8 ir=20020007 rt=2 imm=0007",
                     IAddr, IR, rt, Immediate);
        end
        $display("seq fetch 1: pc=%h ir=%h", IAddr, IR);
    endtask

    task automatic test_branch_jump();
        tick(0, 1, 2'b00, 32'd0, 32'h1000_FFFF);
        tick(1, 0, 2'b01, 32'd0, 32'd0);
        checks++;
        if (IAddr !== 32'd8) begin
            errors++;
            $display("FAIL branch: got pc=%h want 00000008", IAddr);
        end
        $display("branch: pc=%h", IAddr);
        tick(0, 1, 2'b00, 32'd0, 32'h0800_0010);
        checks++;
        if (JumpPC !== 32'h40 || op !== 6'd2) begin
            errors++;
            $display("FAIL jump_target: got jpc=%h op=%h want jpc=00000040 op=02", JumpPC, op);
        end
        tick(1, 0, 2'b11, 32'd0, 32'd0);
        checks++;
        if (IAddr !== 32'h40) begin
            errors++;
            $display("FAIL jump: got pc=%h want 00000040", IAddr);
        end
        $display("jump: pc=%h", IAddr);
    endtask

    task automatic test_fault_misaligned();
        tick(1, 0, 2'b10, 32'h7E, 32'd0);
        checks++;
        if (Fault !== 1'b1 || IAddr !== 32'h40 || RW !== 1'b0 || Halted !== 1'b0) begin
            errors++;
            $display("FAIL misaligned: got f=%b pc=%h rw=%b h=%b want f=1 pc=40 rw=0 h=0",
                     Fault, IAddr, RW, Halted);
        end
        tick(1, 1, 2'b00, 32'd0, 32'h2003_0009);
        checks++;
        if (IAddr !== 32'h40 || IR !== 32'h0800_0010 || Fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_frozen: got pc=%h ir=%h f=%b want pc=40 ir=08000010 f=1",
                     IAddr, IR, Fault);
        end
        $display("misaligned jr: fault=%b pc=%h", Fault, IAddr);
    endtask

    task automatic test_out_of_range();
        test_reset();
        tick(1, 0, 2'b10, 32'h7C, 32'd0);
        checks++;
        if (IAddr !== 32'h7C || Fault !== 1'b0) begin
            errors++;
            $display("FAIL range_edge: got pc=%h f=%b want pc=7c f=0", IAddr, Fault);
        end
        tick(1, 0, 2'b10, 32'h80, 32'd0);
        checks++;
        if (Fault !== 1'b1 || IAddr !== 32'h7C) begin
            errors++;
            $display("FAIL range_over: got f=%b pc=%h want f=1 pc=7c", Fault, IAddr);
        end
        $display("range: pc=%h fault=%b", IAddr, Fault);
    endtask

    task automatic test_halt();
        test_reset();
        for (int i = 0; i < 3; i++) tick(1, 0, 2'b00, 32'd0, 32'd0);
        tick(1, 1, 2'b00, 32'd0, 32'hFC00_0000);
        checks++;
        if (IR !== 32'hFC00_0000 || IAddr !== 32'd16 || Halted !== 1'b1 || RW !== 1'b0 ||
            Fault !== 1'b0) begin
            errors++;
            $display("FAIL halt: got ir=%h pc=%h h=%b rw=%b f=%b want ir=fc000000 pc=10 h=1 rw=0 f=0",
                     IR, IAddr, Halted, RW, Fault);
        end
        tick(1, 1, 2'b00, 32'd0, 32'h2001_0001);
        checks++;
        if (IAddr !== 32'd16 || IR !== 32'hFC00_0000) begin
            errors++;
            $display("FAIL halt_frozen: got pc=%h ir=%h want pc=10 ir=fc000000", IAddr, IR);
        end
        $display("halt: pc=%h halted=%b", IAddr, Halted);
        test_reset();
        checks++;
        if (Halted !== 1'b0 || IAddr !== 32'd0 || RW !== 1'b1) begin
            errors++;
            $display("FAIL halt_reset: got h=%b pc=%h rw=%b want h=0 pc=0 rw=1", Halted, IAddr, RW);
        end
    endtask

    task automatic test_back_to_back();
        test_reset();
        for (int i = 0; i < 5; i++) tick(1, 0, 2'b00, 32'd0, 32'd0);
        tick(0, 1, 2'b00, 32'd0, 32'h1000_FFFF);
        tick(1, 1, 2'b01, 32'd0, 32'h1234_5678);
        checks++;
        if (IAddr !== 32'd20 || IR !== 32'h1234_5678) begin
            errors++;
            $display("FAIL simultaneous: got pc=%h ir=%h want pc=14 ir=12345678", IAddr, IR);
        end
        $display("simultaneous: pc=%h ir=%h", IAddr, IR);
        // Fault and halt raised at one edge: fault wins.
        tick(1, 1, 2'b10, 32'h3, 32'hFC00_0000);
        checks++;
        if (Fault !== 1'b1 || Halted !== 1'b0 || IAddr !== 32'd20) begin
            errors++;
            $display("FAIL fault_over_halt: got f=%b h=%b pc=%h want f=1 h=0 pc=14", Fault, Halted, IAddr);
        end
    endtask

    task automatic test_random();
        logic [31:0] w, regrs;
        logic [1:0]  src;
        bit          pw, iw;
        for (int a = 0; a < MEM_BYTES; a += 4) begin
            w = $urandom;
            if (w[31:26] == 6'h3F || ($urandom % 24) == 0)
                w[31:26] = (($urandom % 24) == 0) ? 6'h3F : 6'h08;
            {mem[a], mem[a+1], mem[a+2], mem[a+3]} = w;
        end
        test_reset();
        for (int n = 0; n < 400; n++) begin
            if ((m_halted || m_fault) && ($urandom % 3) == 0) begin
                test_reset();
                continue;
            end
            pw  = ($urandom % 3) != 0;
            iw  = ($urandom % 2) != 0;
            src = 2'($urandom % 4);
            case ($urandom % 5)
                0:       regrs = 32'($urandom % (MEM_BYTES / 4)) * 4;
                1:       regrs = $urandom;
                2:       regrs = 32'h7C;
                3:       regrs = 32'h80;
                default: regrs = 32'hFFFF_FFFC;
            endcase
            tick(pw, iw, src, regrs, mem_word(IAddr));
            checks++;
            if (IAddr !== m_pc || IR !== m_ir || Halted !== m_halted || Fault !== m_fault ||
                RW !== !(m_halted || m_fault)) begin
                errors++;
                $display("FAIL rand_state[%0d]: got pc=%h ir=%h h=%b f=%b rw=%b want pc=%h ir=%h h=%b f=%b",
                         n, IAddr, IR, Halted, Fault, RW, m_pc, m_ir, m_halted, m_fault);
            end
            checks++;
            if (op !== m_ir[31:26] || rs !== m_ir[25:21] || rt !== m_ir[20:16] ||
                rd !== m_ir[15:11] || Sa !== m_ir[10:6] || Immediate !== m_ir[15:0] ||
                PC4 !== m_pc + 4 ||
                JumpPC !== (((m_pc + 4) & 32'hF000_0000) | (32'(m_ir[25:0]) * 4))) begin
                errors++;
                $display("FAIL rand_fields[%0d]: got op=%h rs=%h rt=%h rd=%h sa=%h imm=%h pc4=%h jpc=%h for ir=%h pc=%h",
                         n, op, rs, rt, rd, Sa, Immediate, PC4, JumpPC, m_ir, m_pc);
            end
            $display("rand %0d: pw=%b iw=%b src=%0d pc=%h ir=%h h=%b f=%b",
                     n, pw, iw, src, IAddr, IR, Halted, Fault);
        end
    endtask

    initial begin
        m_pc = 32'd0; m_ir = 32'd0; m_halted = 0; m_fault = 0;
        Reset = 1'b1;
        #12 Reset = 1'b0;
        test_reset();
        test_sequential();
        test_branch_jump();
        test_fault_misaligned();
        test_out_of_range();
        test_halt();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
